// File: rtl/note_gen_pkg.sv
// Shared types and default geometry for the note-position lane generators.
package note_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } lane_state_t;

  localparam int NOTE_WIDTH = 8;
  localparam int NOTE_START = 200;
  localparam int NOTE_STEP  = 4;
  localparam int NOTE_STOP  = 216;

endpackage

// File: rtl/note_lane.sv
// One playfield lane: walks pos from START toward STOP in STEP increments,
// one step per advancing tick, with restart/abort and wrap/done event pulses.
//
// state | meaning
// IDLE  | parked at START, inactive
// ARMED | parked at START, active, next advancing tick enables stepping
// RUN   | active, stepping on each advancing tick
module note_lane
  import note_gen_pkg::*;
#(
  parameter int WIDTH = NOTE_WIDTH,
  parameter int START = NOTE_START,
  parameter int STEP  = NOTE_STEP,
  parameter int STOP  = NOTE_STOP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  input  logic             start,
  input  logic             stop,
  input  logic             lane_loop,
  output logic             active,
  output logic [WIDTH-1:0] pos,
  output logic             wrap_pulse,
  output logic             done_pulse
);

  if (!(START < STOP && STEP >= 1 && (STOP + STEP) < (2 ** WIDTH))) begin : g_param_check
    $error("note_lane: need START < STOP, STEP >= 1 and STOP + STEP < 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] START_V = WIDTH'(START);
  localparam logic [WIDTH-1:0] STEP_V  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] STOP_V  = WIDTH'(STOP);

  lane_state_t      state, state_nxt;
  logic [WIDTH-1:0] pos_nxt;
  logic             wrap_nxt, done_nxt;

  // State, coordinate and event pulses are all registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pos        <= START_V;
      wrap_pulse <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      pos        <= pos_nxt;
      wrap_pulse <= wrap_nxt;
      done_pulse <= done_nxt;
    end
  end

  // Abort beats arm, arm beats tick; the terminal test happens on the tick
  // after pos reaches STOP, so the last coordinate is held for one step.
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    wrap_nxt  = 1'b0;
    done_nxt  = 1'b0;
    if (stop) begin
      state_nxt = IDLE;
      pos_nxt   = START_V;
    end else if (start) begin
      state_nxt = ARMED;
      pos_nxt   = START_V;
    end else if (adv) begin
      case (state)
        ARMED: state_nxt = RUN;
        RUN: begin
          if (pos < STOP_V) begin
            pos_nxt = pos + STEP_V;
          end else if (lane_loop) begin
            pos_nxt  = START_V;
            wrap_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
            pos_nxt   = START_V;
            done_nxt  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Active whenever the lane has been armed and not yet parked.
  always_comb begin
    active = (state != IDLE);
  end

endmodule

// File: rtl/note_lane_array.sv
// Bank of independent note lanes sharing tick and pause; packs each lane's
// coordinate into lane_pos at [i*WIDTH +: WIDTH].
module note_lane_array
  import note_gen_pkg::*;
#(
  parameter int LANES = 4,
  parameter int WIDTH = NOTE_WIDTH,
  parameter int START = NOTE_START,
  parameter int STEP  = NOTE_STEP,
  parameter int STOP  = NOTE_STOP
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   pause,
  input  logic [LANES-1:0]       lane_start,
  input  logic [LANES-1:0]       lane_stop,
  input  logic [LANES-1:0]       lane_loop,
  output logic [LANES-1:0]       lane_active,
  output logic [LANES*WIDTH-1:0] lane_pos,
  output logic [LANES-1:0]       wrap_pulse,
  output logic [LANES-1:0]       done_pulse
);

  if (LANES < 1) begin : g_lanes_check
    $error("note_lane_array: LANES must be at least 1");
  end

  logic adv;

  // A paused tick is dropped outright rather than queued.
  assign adv = tick & ~pause;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0] pos_i;

    note_lane #(
      .WIDTH(WIDTH),
      .START(START),
      .STEP (STEP),
      .STOP (STOP)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .adv       (adv),
      .start     (lane_start[i]),
      .stop      (lane_stop[i]),
      .lane_loop (lane_loop[i]),
      .active    (lane_active[i]),
      .pos       (pos_i),
      .wrap_pulse(wrap_pulse[i]),
      .done_pulse(done_pulse[i])
    );

    assign lane_pos[i*WIDTH +: WIDTH] = pos_i;
  end

endmodule

// File: tb/tb_note_lane_array.sv
module tb_note_lane_array;

  logic        clk = 1'b0;
  logic        reset, tick, pause;
  logic [3:0]  lane_start, lane_stop, lane_loop;
  logic [3:0]  lane_active, wrap_pulse, done_pulse;
  logic [31:0] lane_pos;

  logic        odd_start, odd_stop, odd_loop;
  logic        odd_active, odd_wrap, odd_done;
  logic [7:0]  odd_pos;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string tag;
    int    lane;   // 0..3 default array, 4 = odd-range instance
    int    pos;
    logic  act;
    logic  wrap;
    logic  done;
  } exp_t;

  exp_t sb[$];

  int seq_loop[7] = '{200, 204, 208, 212, 216, 200, 204};
  int seq_odd[7]  = '{0, 3, 6, 9, 12, 0, 3};

  always #5 clk = ~clk;

  note_lane_array #(
    .LANES(4), .WIDTH(8), .START(200), .STEP(4), .STOP(216)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .pause      (pause),
    .lane_start (lane_start),
    .lane_stop  (lane_stop),
    .lane_loop  (lane_loop),
    .lane_active(lane_active),
    .lane_pos   (lane_pos),
    .wrap_pulse (wrap_pulse),
    .done_pulse (done_pulse)
  );

  note_lane_array #(
    .LANES(1), .WIDTH(8), .START(0), .STEP(3), .STOP(10)
  ) dut_odd (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .pause      (pause),
    .lane_start (odd_start),
    .lane_stop  (odd_stop),
    .lane_loop  (odd_loop),
    .lane_active(odd_active),
    .lane_pos   (odd_pos),
    .wrap_pulse (odd_wrap),
    .done_pulse (odd_done)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic exp_lane(input string tag, input int lane, input int pos,
                          input logic act, input logic wrap, input logic done);
    exp_t e;
    e.tag = tag; e.lane = lane; e.pos = pos;
    e.act = act; e.wrap = wrap; e.done = done;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [7:0] p;
    logic a, w, d;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.lane == 4) begin
        p = odd_pos; a = odd_active; w = odd_wrap; d = odd_done;
      end else begin
        p = lane_pos[e.lane*8 +: 8];
        a = lane_active[e.lane];
        w = wrap_pulse[e.lane];
        d = done_pulse[e.lane];
      end
      check_val($sformatf("%s l%0d pos",  e.tag, e.lane), 32'(p), 32'(e.pos));
      check_val($sformatf("%s l%0d act",  e.tag, e.lane), 32'(a), 32'(e.act));
      check_val($sformatf("%s l%0d wrap", e.tag, e.lane), 32'(w), 32'(e.wrap));
      check_val($sformatf("%s l%0d done", e.tag, e.lane), 32'(d), 32'(e.done));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tick = 1'b0; pause = 1'b0;
    lane_start = '0; lane_stop = '0; lane_loop = '0;
    odd_start = 1'b0; odd_stop = 1'b0; odd_loop = 1'b0;

    #2;
    for (int l = 0; l < 4; l++) exp_lane("reset", l, 200, 0, 0, 0);
    exp_lane("reset", 4, 0, 0, 0, 0);
    drain();
    cycle();
    reset = 1'b0;

    // lane 0 looping
    lane_loop = 4'b1101;
    lane_start = 4'b0001;
    exp_lane("loop arm", 0, 200, 1, 0, 0);
    cycle();
    lane_start = '0;
    tick = 1'b1;
    for (int i = 0; i < 7; i++) begin
      exp_lane("loop seq", 0, seq_loop[i], 1, (i == 5), 0);
      cycle();
    end
    tick = 1'b0;
    lane_stop = 4'b0001;
    exp_lane("loop stop", 0, 200, 0, 0, 0);
    cycle();
    lane_stop = '0;

    // lane 1 one-shot
    lane_start = 4'b0010;
    exp_lane("once arm", 1, 200, 1, 0, 0);
    cycle();
    lane_start = '0;
    tick = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_lane("once seq", 1, seq_loop[i], 1, 0, 0);
      cycle();
    end
    exp_lane("once done", 1, 200, 0, 0, 1);
    cycle();
    exp_lane("once after", 1, 200, 0, 0, 0);
    cycle();
    exp_lane("once after2", 1, 200, 0, 0, 0);
    cycle();
    tick = 1'b0;

    // lane 2 simultaneous start/stop, then restart
    lane_start = 4'b0100;
    exp_lane("sim arm", 2, 200, 1, 0, 0);
    cycle();
    lane_start = '0;
    tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_lane("sim run", 2, seq_loop[i], 1, 0, 0);
      cycle();
    end
    lane_start = 4'b0100; lane_stop = 4'b0100;
    exp_lane("sim both", 2, 200, 0, 0, 0);
    cycle();
    lane_stop = '0; tick = 1'b0;
    exp_lane("sim rearm", 2, 200, 1, 0, 0);
    cycle();
    lane_start = '0; tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_lane("sim run2", 2, seq_loop[i], 1, 0, 0);
      cycle();
    end
    tick = 1'b0; lane_start = 4'b0100;
    exp_lane("sim restart", 2, 200, 1, 0, 0);
    cycle();
    lane_start = '0; tick = 1'b1;
    exp_lane("sim armtick", 2, 200, 1, 0, 0);
    cycle();
    exp_lane("sim step", 2, 204, 1, 0, 0);
    cycle();
    tick = 1'b0; lane_stop = 4'b0100;
    exp_lane("sim stop", 2, 200, 0, 0, 0);
    cycle();
    lane_stop = '0;

    // lane 3 pause
    lane_start = 4'b1000;
    exp_lane("pause arm", 3, 200, 1, 0, 0);
    cycle();
    lane_start = '0; tick = 1'b1;
    exp_lane("pause run", 3, 200, 1, 0, 0);
    cycle();
    exp_lane("pause run", 3, 204, 1, 0, 0);
    cycle();
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_lane("paused", 3, 204, 1, 0, 0);
      cycle();
    end
    pause = 1'b0;
    exp_lane("unpaused", 3, 208, 1, 0, 0);
    cycle();
    tick = 1'b0; lane_stop = 4'b1000;
    exp_lane("pause stop", 3, 200, 0, 0, 0);
    cycle();
    lane_stop = '0;

    // staggered starts, one lane per tick
    lane_loop = 4'b1111; tick = 1'b1;
    lane_start = 4'b0001;
    exp_lane("stag0", 0, 200, 1, 0, 0);
    cycle();
    lane_start = 4'b0010;
    exp_lane("stag1", 0, 200, 1, 0, 0);
    exp_lane("stag1", 1, 200, 1, 0, 0);
    cycle();
    lane_start = 4'b0100;
    exp_lane("stag2", 0, 204, 1, 0, 0);
    exp_lane("stag2", 1, 200, 1, 0, 0);
    exp_lane("stag2", 2, 200, 1, 0, 0);
    cycle();
    lane_start = 4'b1000;
    exp_lane("stag3", 0, 208, 1, 0, 0);
    exp_lane("stag3", 1, 204, 1, 0, 0);
    exp_lane("stag3", 2, 200, 1, 0, 0);
    exp_lane("stag3", 3, 200, 1, 0, 0);
    cycle();
    lane_start = '0;
    exp_lane("stag4", 0, 212, 1, 0, 0);
    exp_lane("stag4", 1, 208, 1, 0, 0);
    exp_lane("stag4", 2, 204, 1, 0, 0);
    exp_lane("stag4", 3, 200, 1, 0, 0);
    cycle();
    exp_lane("stag5", 0, 216, 1, 0, 0);
    exp_lane("stag5", 1, 212, 1, 0, 0);
    exp_lane("stag5", 2, 208, 1, 0, 0);
    exp_lane("stag5", 3, 204, 1, 0, 0);
    cycle();
    tick = 1'b0;

    // async reset between edges
    #2;
    reset = 1'b1;
    #1;
    for (int l = 0; l < 4; l++) exp_lane("async rst", l, 200, 0, 0, 0);
    drain();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // odd range: START 0, STEP 3, STOP 10
    odd_loop = 1'b1; odd_start = 1'b1;
    exp_lane("odd arm", 4, 0, 1, 0, 0);
    cycle();
    odd_start = 1'b0; tick = 1'b1;
    for (int i = 0; i < 7; i++) begin
      exp_lane("odd seq", 4, seq_odd[i], 1, (i == 5), 0);
      cycle();
    end
    tick = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
